// File: rtl/ecg_beat_det.sv
// ecg_beat_det: R-peak detector for a signed 8-bit ECG sample stream.
// Threshold crossing starts an excursion, the first sample below threshold
// ends it and reports a beat (peak amplitude, R-R interval), then a
// refractory window ignores REFRACT valid samples.
// Optional feature macro: ECG_BEAT_AVG_EN (4-beat R-R average).
module ecg_beat_det #(
  parameter logic signed [7:0] THRESH   = 8'sh30,
  parameter int unsigned       REFRACT  = 32,
  parameter int unsigned       PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [7:0]          sample_in,
  output logic                beat_valid,
  output logic [7:0]          peak_amp,
  output logic [PERIOD_W-1:0] rr_period,
  output logic                rr_valid,
  output logic                lock,
  output logic [PERIOD_W-1:0] rr_avg,
  output logic                avg_valid
);

  localparam int unsigned RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  typedef enum logic [1:0] {SEARCH, ABOVE, REFR} state_t;

  state_t                state_q, state_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic signed [7:0]     max_q, max_d;
  logic [PERIOD_W-1:0]   rr_pend_q, rr_pend_d;
  logic                  rr_ok_q, rr_ok_d;
  logic                  first_q, first_d;
  logic [RW-1:0]         ref_q, ref_d;
  logic                  beat_q, beat_d;
  logic [7:0]            peak_q, peak_d;
  logic [PERIOD_W-1:0]   rrp_q, rrp_d;
  logic                  rrv_q, rrv_d;
  logic                  lock_q, lock_d;

  logic signed [7:0]     samp;
  logic                  above;
  logic                  cnt_sat;

  assign samp    = $signed(sample_in);
  assign above   = (samp >= THRESH);
  assign cnt_sat = (cnt_q == '1);

  // Detection FSM, interval counter and beat reporting (next-state logic)
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    rr_pend_d = rr_pend_q;
    rr_ok_d   = rr_ok_q;
    first_d   = first_q;
    ref_d     = ref_q;
    beat_d    = 1'b0;
    peak_d    = peak_q;
    rrp_d     = rrp_q;
    rrv_d     = rrv_q;
    lock_d    = lock_q;

    if (sample_valid) begin
      if (!cnt_sat) cnt_d = cnt_q + PERIOD_W'(1);
      case (state_q)
        SEARCH: begin
          if (above) begin
            state_d   = ABOVE;
            max_d     = samp;
            rr_pend_d = cnt_q + PERIOD_W'(1);
            rr_ok_d   = !first_q && !cnt_sat;
            cnt_d     = '0;
            first_d   = 1'b0;
          end
        end
        ABOVE: begin
          if (above) begin
            if (samp > max_q) max_d = samp;
          end else begin
            state_d = REFR;
            ref_d   = RW'(REFRACT - 1);
            beat_d  = 1'b1;
            peak_d  = max_q;
            rrp_d   = rr_pend_q;
            rrv_d   = rr_ok_q;
            if (rr_ok_q) lock_d = 1'b1;
          end
        end
        REFR: begin
          if (ref_q == '0) state_d = SEARCH;
          else             ref_d   = ref_q - RW'(1);
        end
        default: state_d = SEARCH;
      endcase
    end

    // Timeout overrides any lock set in the same cycle
    if (cnt_sat) lock_d = 1'b0;
  end

  // Detection state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      cnt_q     <= '0;
      max_q     <= '0;
      rr_pend_q <= '0;
      rr_ok_q   <= 1'b0;
      first_q   <= 1'b1;
      ref_q     <= '0;
      beat_q    <= 1'b0;
      peak_q    <= '0;
      rrp_q     <= '0;
      rrv_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      rr_pend_q <= rr_pend_d;
      rr_ok_q   <= rr_ok_d;
      first_q   <= first_d;
      ref_q     <= ref_d;
      beat_q    <= beat_d;
      peak_q    <= peak_d;
      rrp_q     <= rrp_d;
      rrv_q     <= rrv_d;
      lock_q    <= lock_d;
    end
  end

  assign beat_valid = beat_q;
  assign peak_amp   = peak_q;
  assign rr_period  = rrp_q;
  assign rr_valid   = rrv_q;
  assign lock       = lock_q;

`ifdef ECG_BEAT_AVG_EN
  logic [3:0][PERIOD_W-1:0] hist_q, hist_d;
  logic [2:0]               fill_q, fill_d;
  logic                     upd_q, upd_d;
  logic [PERIOD_W-1:0]      avg_q, avg_d;
  logic                     avgv_q, avgv_d;
  logic [PERIOD_W+1:0]      sum_w;
  logic                     lock_drop;

  assign lock_drop = lock_q && !lock_d;

  // Sum of the four history entries
  always_comb begin
    sum_w = '0;
    for (int unsigned i = 0; i < 4; i++) sum_w = sum_w + (PERIOD_W + 2)'(hist_q[i]);
  end

  // History shift on valid beats; average is published one cycle after the beat
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    upd_d  = 1'b0;
    avg_d  = avg_q;
    avgv_d = avgv_q;

    if (upd_q) begin
      avg_d  = sum_w[PERIOD_W+1:2];
      avgv_d = (fill_q == 3'd4);
    end

    if (beat_d) begin
      if (rrv_d) begin
        hist_d[0] = rrp_d;
        for (int unsigned i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
        fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
        upd_d  = 1'b1;
      end else begin
        hist_d = '0;
        fill_d = '0;
        avgv_d = 1'b0;
      end
    end

    if (lock_drop) begin
      hist_d = '0;
      fill_d = '0;
      upd_d  = 1'b0;
      avgv_d = 1'b0;
    end
  end

  // Average history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      upd_q  <= 1'b0;
      avg_q  <= '0;
      avgv_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      upd_q  <= upd_d;
      avg_q  <= avg_d;
      avgv_q <= avgv_d;
    end
  end

  assign rr_avg    = avg_q;
  assign avg_valid = avgv_q;
`else
  assign rr_avg    = '0;
  assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ecg_beat_det.sv
// tb_ecg_beat_det: directed self-checking bench for ecg_beat_det.
// Stimulus is a 64-sample synthetic ECG period: crossing at phase 31
// (exactly THRESH), peak 0x64 at phase 32, fall at phase 35, plus a
// negative 0xE1 and a just-below 0x2F sample in the baseline.
module tb_ecg_beat_det;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample_in = '0;
  logic        beat_valid;
  logic [7:0]  peak_amp;
  logic [15:0] rr_period;
  logic        rr_valid;
  logic        lock;
  logic [15:0] rr_avg;
  logic        avg_valid;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int beats    = 0;
  logic prev_bv = 1'b0;
  int pb, bph, bcyc;

  ecg_beat_det #(.THRESH(8'sh30), .REFRACT(32), .PERIOD_W(16)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .beat_valid(beat_valid), .peak_amp(peak_amp), .rr_period(rr_period),
    .rr_valid(rr_valid), .lock(lock), .rr_avg(rr_avg), .avg_valid(avg_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] wave(input int p);
    case (p)
      10:      wave = 8'hE1;
      20:      wave = 8'h2F;
      31:      wave = 8'h30;
      32:      wave = 8'h64;
      33:      wave = 8'h50;
      34:      wave = 8'h38;
      35:      wave = 8'h10;
      default: wave = 8'h00;
    endcase
  endfunction

  // One clock: drive on the falling edge, observe 1 time unit after the rising edge
  task automatic step(input logic v, input logic [7:0] s);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    @(posedge clk);
    #1;
    cycle++;
    if (prev_bv) begin
      checks++;
      if (beat_valid !== 1'b0) begin
        failures++;
        $display("FAIL beat_pulse_width: beat_valid=%b required 0 at cycle %0d", beat_valid, cycle);
      end
    end
    if (beat_valid === 1'b1) begin
      beats++;
      bcyc = cycle;
    end
    prev_bv = (beat_valid === 1'b1);
  endtask

  // One waveform period, extra baseline samples appended, optional injected 0x50
  task automatic run_period(input int extra, input int inject_ph, input bit half);
    int b0;
    logic [7:0] s;
    b0  = beats;
    bph = -1;
    for (int p = 0; p < 64; p++) begin
      s = (p == inject_ph) ? 8'h50 : wave(p);
      step(1'b1, s);
      if (beat_valid === 1'b1) bph = p;
      if (half) step(1'b0, 8'h7F);
    end
    for (int i = 0; i < extra; i++) step(1'b1, 8'h00);
    pb = beats - b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h64);
    checks++; if (beat_valid !== 1'b0) begin failures++; $display("FAIL reset_beat_valid: got %b want 0", beat_valid); end
    checks++; if (peak_amp !== 8'h00) begin failures++; $display("FAIL reset_peak_amp: got %h want 00", peak_amp); end
    checks++; if (rr_period !== 16'd0) begin failures++; $display("FAIL reset_rr_period: got %0d want 0", rr_period); end
    checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL reset_rr_valid: got %b want 0", rr_valid); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock: got %b want 0", lock); end
    checks++; if (rr_avg !== 16'd0) begin failures++; $display("FAIL reset_rr_avg: got %0d want 0", rr_avg); end
    checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL reset_avg_valid: got %b want 0", avg_valid); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_period(0, -1, 1'b0);
    checks++; if (pb !== 1) begin failures++; $display("FAIL first_beat_count: got %0d want 1", pb); end
    checks++; if (bph !== 35) begin failures++; $display("FAIL first_beat_phase: got %0d want 35", bph); end
    checks++; if (peak_amp !== 8'h64) begin failures++; $display("FAIL first_peak_amp: got %h want 64", peak_amp); end
    checks++; if (rr_period !== 16'd32) begin failures++; $display("FAIL first_rr_period: got %0d want 32", rr_period); end
    checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL first_rr_valid: got %b want 0", rr_valid); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL first_lock: got %b want 0", lock); end
    run_period(0, -1, 1'b0);
    checks++; if (pb !== 1) begin failures++; $display("FAIL second_beat_count: got %0d want 1", pb); end
    checks++; if (bph !== 35) begin failures++; $display("FAIL second_beat_phase: got %0d want 35", bph); end
    checks++; if (rr_period !== 16'd64) begin failures++; $display("FAIL second_rr_period: got %0d want 64", rr_period); end
    checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL second_rr_valid: got %b want 1", rr_valid); end
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL second_lock: got %b want 1", lock); end
  endtask

  task automatic test_half_rate;
    int c1;
    run_period(0, -1, 1'b1);
    c1 = bcyc;
    checks++; if (pb !== 1) begin failures++; $display("FAIL half_beat_count: got %0d want 1", pb); end
    checks++; if (rr_period !== 16'd64) begin failures++; $display("FAIL half_rr_period_a: got %0d want 64", rr_period); end
    run_period(0, -1, 1'b1);
    checks++; if (bcyc - c1 !== 128) begin failures++; $display("FAIL half_beat_spacing: got %0d want 128", bcyc - c1); end
    checks++; if (rr_period !== 16'd64) begin failures++; $display("FAIL half_rr_period_b: got %0d want 64", rr_period); end
    checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL half_rr_valid: got %b want 1", rr_valid); end
  endtask

  task automatic test_refract_inject;
    run_period(0, 45, 1'b0);
    checks++; if (pb !== 1) begin failures++; $display("FAIL refract_beat_count: got %0d want 1", pb); end
    checks++; if (bph !== 35) begin failures++; $display("FAIL refract_beat_phase: got %0d want 35", bph); end
    run_period(0, -1, 1'b0);
    checks++; if (rr_period !== 16'd64) begin failures++; $display("FAIL refract_next_rr: got %0d want 64", rr_period); end
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL refract_lock: got %b want 1", lock); end
  endtask

  task automatic test_avg;
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
    run_period(0, -1, 1'b0);
    run_period(0, -1, 1'b0);
    run_period(0, -1, 1'b0);
    run_period(4, -1, 1'b0);
`ifdef ECG_BEAT_AVG_EN
    checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL avg_valid_three: got %b want 0", avg_valid); end
`endif
    run_period(0, -1, 1'b0);
    checks++; if (rr_period !== 16'd68) begin failures++; $display("FAIL avg_rr_68: got %0d want 68", rr_period); end
    checks++; if (rr_valid !== 1'b1) begin failures++; $display("FAIL avg_rr_valid: got %b want 1", rr_valid); end
`ifdef ECG_BEAT_AVG_EN
    checks++; if (rr_avg !== 16'd65) begin failures++; $display("FAIL avg_value: got %0d want 65", rr_avg); end
    checks++; if (avg_valid !== 1'b1) begin failures++; $display("FAIL avg_valid_four: got %b want 1", avg_valid); end
`else
    checks++; if (rr_avg !== 16'd0) begin failures++; $display("FAIL avg_tied_value: got %0d want 0", rr_avg); end
    checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL avg_tied_valid: got %b want 0", avg_valid); end
`endif
  endtask

  task automatic test_timeout;
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL timeout_pre_lock: got %b want 1", lock); end
    for (int i = 0; i < 65400; i++) step(1'b1, 8'h00);
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL timeout_early_lock: got %b want 1", lock); end
    for (int i = 65400; i < 65536; i++) step(1'b1, 8'h00);
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL timeout_lock: got %b want 0", lock); end
`ifdef ECG_BEAT_AVG_EN
    checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL timeout_avg_valid: got %b want 0", avg_valid); end
`endif
    run_period(0, -1, 1'b0);
    checks++; if (pb !== 1) begin failures++; $display("FAIL timeout_beat_count: got %0d want 1", pb); end
    checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL timeout_rr_valid: got %b want 0", rr_valid); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL timeout_post_lock: got %b want 0", lock); end
    run_period(0, -1, 1'b0);
    checks++; if (rr_period !== 16'd64) begin failures++; $display("FAIL relock_rr: got %0d want 64", rr_period); end
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL relock_lock: got %b want 1", lock); end
  endtask

  task automatic test_reset_mid;
    int b0;
    for (int p = 0; p < 32; p++) step(1'b1, wave(p));
    rst = 1'b1;
    step(1'b1, wave(32));
    rst = 1'b0;
    checks++; if (beat_valid !== 1'b0) begin failures++; $display("FAIL mid_beat_valid: got %b want 0", beat_valid); end
    checks++; if (peak_amp !== 8'h00) begin failures++; $display("FAIL mid_peak_amp: got %h want 00", peak_amp); end
    checks++; if (rr_period !== 16'd0) begin failures++; $display("FAIL mid_rr_period: got %0d want 0", rr_period); end
    checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL mid_rr_valid: got %b want 0", rr_valid); end
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL mid_lock: got %b want 0", lock); end
    checks++; if (rr_avg !== 16'd0) begin failures++; $display("FAIL mid_rr_avg: got %0d want 0", rr_avg); end
    checks++; if (avg_valid !== 1'b0) begin failures++; $display("FAIL mid_avg_valid: got %b want 0", avg_valid); end
    // The interrupted excursion is replaced by baseline after reset
    b0 = beats;
    for (int p = 33; p < 64; p++) step(1'b1, 8'h00);
    checks++; if (beats - b0 !== 0) begin failures++; $display("FAIL mid_no_beat: got %0d want 0", beats - b0); end
    run_period(0, -1, 1'b0);
    checks++; if (pb !== 1) begin failures++; $display("FAIL mid_next_count: got %0d want 1", pb); end
    checks++; if (bph !== 35) begin failures++; $display("FAIL mid_next_phase: got %0d want 35", bph); end
    checks++; if (peak_amp !== 8'h64) begin failures++; $display("FAIL mid_next_peak: got %h want 64", peak_amp); end
    checks++; if (rr_period !== 16'd63) begin failures++; $display("FAIL mid_next_rr: got %0d want 63", rr_period); end
    checks++; if (rr_valid !== 1'b0) begin failures++; $display("FAIL mid_next_rr_valid: got %b want 0", rr_valid); end
    run_period(0, -1, 1'b0);
    checks++; if (rr_period !== 16'd64) begin failures++; $display("FAIL mid_second_rr: got %0d want 64", rr_period); end
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL mid_second_lock: got %b want 1", lock); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_half_rate;
    test_refract_inject;
    test_avg;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
